// File: rtl/jtbubl_sdram_pkg.sv
// Shared types and default parameters for the jtbubl SDRAM responder model.
package jtbubl_sdram_pkg;

    // Controller states. Read and write are single transactions; refresh blocks the port.
    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StRefresh
    } state_e;

    localparam int unsigned DefMemAw     = 16;
    localparam int unsigned DefReadLat   = 4;
    localparam int unsigned DefRefPeriod = 384;
    localparam int unsigned DefRefLen    = 4;

    // Cycles spent in StWrite after the write is accepted.
    localparam int unsigned WriteLen = 2;

    // Width of the shared busy down-counter (covers READ_LAT up to 15 and REF_LEN up to 33).
    localparam int unsigned BusyW = 5;

    // prog_mask is active-low: a 0 bit enables that byte lane.
    function automatic logic [1:0] lane_we(input logic [1:0] mask);
        return ~mask;
    endfunction

endpackage

// File: rtl/jtbubl_sdram_mem.sv
// 16-bit word memory with byte-lane write enables and a dual-word registered read.
// The second read word comes from the next address, wrapping at the top of the array.
module jtbubl_sdram_mem #(
    parameter int unsigned MEM_AW = 16
) (
    input  logic              clk_i,
    input  logic [MEM_AW-1:0] wr_addr_i,
    input  logic [15:0]       wr_data_i,
    input  logic [1:0]        wr_be_i,
    input  logic [MEM_AW-1:0] rd_addr_i,
    output logic [31:0]       rd_data_o
);

    localparam int unsigned Depth = 1 << MEM_AW;

    logic [15:0]       mem_q [Depth];
    logic [31:0]       rd_data_q;
    logic [MEM_AW-1:0] rd_addr_nxt;

    // Natural wrap of the MEM_AW-bit sum gives (addr+1) mod 2^MEM_AW.
    assign rd_addr_nxt = rd_addr_i + MEM_AW'(1);

    // Byte-lane writes and a one-cycle-latency read of {mem[addr+1], mem[addr]}.
    always_ff @(posedge clk_i) begin
        if (wr_be_i[0]) begin
            mem_q[wr_addr_i][7:0] <= wr_data_i[7:0];
        end
        if (wr_be_i[1]) begin
            mem_q[wr_addr_i][15:8] <= wr_data_i[15:8];
        end
        rd_data_q <= {mem_q[rd_addr_nxt], mem_q[rd_addr_i]};
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/jtbubl_sdram_resp.sv
// Behavioural SDRAM responder: arbitrates ROM-download writes, CPU reads and periodic
// refresh onto a local memory, with fixed read latency and registered handshake outputs.
module jtbubl_sdram_resp
    import jtbubl_sdram_pkg::*;
#(
    parameter int unsigned MEM_AW     = DefMemAw,
    parameter int unsigned READ_LAT   = DefReadLat,    // 2..15
    parameter int unsigned REF_PERIOD = DefRefPeriod,
    parameter int unsigned REF_LEN    = DefRefLen      // 2..33
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        downloading_i,
    input  logic [21:0] prog_addr_i,
    input  logic [7:0]  prog_data_i,
    input  logic [1:0]  prog_mask_i,
    input  logic        prog_we_i,
    input  logic        sdram_req_i,
    input  logic [21:0] sdram_addr_i,
    input  logic        refresh_en_i,
    output logic        sdram_ack_o,
    output logic        data_rdy_o,
    output logic [31:0] data_read_o
);

    localparam int unsigned RefCntW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

    state_e             state_q;
    logic [BusyW-1:0]   busy_q;
    logic [MEM_AW-1:0]  rd_addr_q;
    logic               ack_q;
    logic               rdy_q;
    logic [31:0]        data_q;
    logic [RefCntW-1:0] ref_cnt_q;
    logic               ref_pend_q;

    logic               ref_expire;
    logic               is_idle;
    logic               take_ref;
    logic               take_wr;
    logic               take_rd;
    logic [1:0]         mem_be;
    logic [31:0]        mem_rdata;

    // Only the low MEM_AW address bits select a word.
    if (MEM_AW < 22) begin : g_addr_unused
        logic unused_addr_bits;
        assign unused_addr_bits = ^{prog_addr_i[21:MEM_AW], sdram_addr_i[21:MEM_AW]};
    end

    // Arbitration from IDLE: refresh first, then download writes, then reads.
    assign ref_expire = (ref_cnt_q == RefCntW'(REF_PERIOD - 1));
    assign is_idle    = (state_q == StIdle);
    assign take_ref   = is_idle && ref_pend_q && refresh_en_i;
    assign take_wr    = is_idle && !take_ref && prog_we_i && downloading_i;
    assign take_rd    = is_idle && !take_ref && !downloading_i && sdram_req_i;

    // A reset cycle must not commit a write that the FSM never acknowledges.
    assign mem_be = (take_wr && !rst_i) ? lane_we(prog_mask_i) : 2'b00;

    jtbubl_sdram_mem #(
        .MEM_AW (MEM_AW)
    ) u_mem (
        .clk_i     (clk_i),
        .wr_addr_i (prog_addr_i[MEM_AW-1:0]),
        .wr_data_i ({2{prog_data_i}}),
        .wr_be_i   (mem_be),
        .rd_addr_i (rd_addr_q),
        .rd_data_o (mem_rdata)
    );

    // Free-running refresh timer; a pending refresh never queues a second one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
        end else begin
            ref_cnt_q <= ref_expire ? '0 : ref_cnt_q + RefCntW'(1);
            if (ref_expire) begin
                ref_pend_q <= 1'b1;
            end else if (take_ref) begin
                ref_pend_q <= 1'b0;
            end
        end
    end

    // Main FSM with registered ack/ready/data outputs.
    // The IDLE cycle that issues a refresh counts as its first busy cycle, so the port is
    // unavailable for exactly REF_LEN cycles; StRefresh covers the remaining REF_LEN-1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            busy_q    <= '0;
            rd_addr_q <= '0;
            ack_q     <= 1'b0;
            rdy_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            ack_q <= 1'b0;
            rdy_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (take_ref) begin
                        state_q <= StRefresh;
                        busy_q  <= BusyW'(REF_LEN - 2);
                    end else if (take_wr) begin
                        state_q <= StWrite;
                        ack_q   <= 1'b1;
                        busy_q  <= BusyW'(WriteLen - 1);
                    end else if (take_rd) begin
                        state_q   <= StRead;
                        ack_q     <= 1'b1;
                        rd_addr_q <= sdram_addr_i[MEM_AW-1:0];
                        busy_q    <= BusyW'(READ_LAT - 1);
                    end
                end
                StRead: begin
                    // Memory output is valid from the second READ cycle onward.
                    if (busy_q == '0) begin
                        state_q <= StIdle;
                        rdy_q   <= 1'b1;
                        data_q  <= mem_rdata;
                    end else begin
                        busy_q <= busy_q - BusyW'(1);
                    end
                end
                StWrite, StRefresh: begin
                    if (busy_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        busy_q <= busy_q - BusyW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign sdram_ack_o = ack_q;
    assign data_rdy_o  = rdy_q;
    assign data_read_o = data_q;

endmodule

// File: tb/tb_jtbubl_sdram_resp.sv
// Directed/randomized bench for jtbubl_sdram_resp with a word-array memory model and
// cycle-count expectations derived from the handshake timing rules.
module tb_jtbubl_sdram_resp;

    localparam int unsigned AW    = 8;
    localparam int          DEPTH = 1 << AW;
    localparam int          RL    = 4;
    localparam int          RP    = 384;
    localparam int          RLEN  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        downloading;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        refresh_en;
    logic        sdram_ack;
    logic        data_rdy;
    logic [31:0] data_read;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] model [DEPTH];

    jtbubl_sdram_resp #(
        .MEM_AW     (AW),
        .READ_LAT   (RL),
        .REF_PERIOD (RP),
        .REF_LEN    (RLEN)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .downloading_i (downloading),
        .prog_addr_i   (prog_addr),
        .prog_data_i   (prog_data),
        .prog_mask_i   (prog_mask),
        .prog_we_i     (prog_we),
        .sdram_req_i   (sdram_req),
        .sdram_addr_i  (sdram_addr),
        .refresh_en_i  (refresh_en),
        .sdram_ack_o   (sdram_ack),
        .data_rdy_o    (data_rdy),
        .data_read_o   (data_read)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_word(input int addr);
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        a0 = addr[AW-1:0];
        a1 = a0 + AW'(1);
        return {model[a1], model[a0]};
    endfunction

    task automatic do_reset();
        rst         = 1'b1;
        downloading = 1'b0;
        prog_addr   = '0;
        prog_data   = '0;
        prog_mask   = 2'b11;
        prog_we     = 1'b0;
        sdram_req   = 1'b0;
        sdram_addr  = '0;
        refresh_en  = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_ack(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (sdram_ack === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic finish_read(input int addr, input int ack_cyc);
        int rdy_cyc;
        rdy_cyc = -1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (data_rdy === 1'b1) begin
                rdy_cyc = cyc;
                break;
            end
        end
        check("rd_latency", rdy_cyc - ack_cyc, RL);
        check("rd_data", data_read, exp_word(addr));
        step();
        check("rdy_pulse", 32'(data_rdy), 0);
        check("rd_hold", data_read, exp_word(addr));
    endtask

    task automatic do_read(input int addr, input int exp_lat);
        int lat;
        int ack_cyc;
        downloading = 1'b0;
        sdram_addr  = {14'($urandom), 8'(addr)};
        sdram_req   = 1'b1;
        wait_ack(lat);
        sdram_req = 1'b0;
        ack_cyc   = cyc;
        check("rd_ack_lat", lat, exp_lat);
        finish_read(addr, ack_cyc);
    endtask

    task automatic do_write(input int addr, input logic [7:0] data, input logic [1:0] mask);
        int lat;
        downloading = 1'b1;
        prog_addr   = {14'($urandom), 8'(addr)};
        prog_data   = data;
        prog_mask   = mask;
        prog_we     = 1'b1;
        wait_ack(lat);
        prog_we = 1'b0;
        check("wr_ack_lat", lat, 1);
        if (!mask[0]) model[addr][7:0] = data;
        if (!mask[1]) model[addr][15:8] = data;
        step();
        check("wr_ack_pulse", 32'(sdram_ack), 0);
        step();
    endtask

    initial begin
        int a;
        int lat;
        int ack_cyc;
        int last_ack;
        int gap;
        int stalls;
        int exp_rdy [$];
        int exp_addr [$];
        logic exp_now;

        // Reset state
        do_reset();
        check("reset_ack", 32'(sdram_ack), 0);
        check("reset_rdy", 32'(data_rdy), 0);
        check("reset_data", data_read, 0);

        // Preload every word so the model is fully known
        for (int i = 0; i < DEPTH; i++) begin
            do_write(i, 8'($urandom), 2'b00);
        end

        // Lane-masked writes merge into one word
        do_write(32'h10, 8'hA5, 2'b10);
        do_write(32'h10, 8'h3C, 2'b01);
        do_read(32'h10, 1);
        check("lane_merge", {16'h0, data_read[15:0]}, 32'h3CA5);

        // Top-of-memory read wraps to word 0
        do_read(DEPTH - 1, 1);
        check("wrap_hi_word", {16'h0, data_read[31:16]}, {16'h0, model[0]});

        // Random mix of writes (any mask) and reads
        for (int n = 0; n < 40; n++) begin
            a = $urandom_range(0, DEPTH - 1);
            if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom), 2'($urandom));
            else do_read(a, 1);
        end

        // Held all-masked write: re-accepted only from IDLE, memory untouched
        downloading = 1'b1;
        prog_addr   = 22'h20;
        prog_mask   = 2'b11;
        prog_data   = 8'hFF;
        prog_we     = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            check("held_wr_ack", 32'(sdram_ack), 32'((k % 3) == 1));
        end
        prog_we = 1'b0;
        step();
        step();
        do_read(32'h20, 1);

        // Reset two cycles after a read ack suppresses data_rdy
        downloading = 1'b0;
        sdram_addr  = 22'h33;
        sdram_req   = 1'b1;
        wait_ack(lat);
        sdram_req = 1'b0;
        check("pre_rst_ack_lat", lat, 1);
        step();
        step();
        rst = 1'b1;
        step();
        check("rst_ack", 32'(sdram_ack), 0);
        check("rst_rdy", 32'(data_rdy), 0);
        check("rst_data", data_read, 0);
        rst = 1'b0;
        cyc = 0;
        for (int k = 0; k < RL + 2; k++) begin
            step();
            check("rst_no_rdy", 32'(data_rdy), 0);
        end

        // Memory survives reset
        do_read(32'h10, 1);

        // Refresh becoming pending as a read is raised delays the ack by REF_LEN
        refresh_en = 1'b1;
        do_read($urandom_range(0, DEPTH - 1), 1);
        while (cyc < RP) step();
        do_read($urandom_range(0, DEPTH - 1), 1 + RLEN);

        // Reads are never acked while downloading; ack follows the drop promptly
        while (cyc < 2 * RP - 25) step();
        refresh_en  = 1'b0;
        downloading = 1'b1;
        prog_we     = 1'b0;
        a           = $urandom_range(0, DEPTH - 1);
        sdram_addr  = 22'(a);
        sdram_req   = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            check("dl_no_ack", 32'(sdram_ack), 0);
        end
        downloading = 1'b0;
        refresh_en  = 1'b1;
        wait_ack(lat);
        sdram_req = 1'b0;
        ack_cyc   = cyc;
        check("dl_drop_ack_window", 32'(lat >= 1 && lat <= 1 + RLEN), 1);
        finish_read(a, ack_cyc);

        // Back-to-back held reads; one refresh after refresh_en rises at cycle 1000
        do_reset();
        sdram_addr = 22'($urandom_range(0, DEPTH - 1));
        last_ack   = -1;
        stalls     = 0;
        while ((cyc < 1150 || exp_rdy.size() > 0) && cyc < 1300) begin
            if (cyc == 1000) refresh_en = 1'b1;
            sdram_req = (cyc < 1150);
            step();
            if (sdram_ack === 1'b1) begin
                if (last_ack >= 0) begin
                    gap = cyc - last_ack;
                    if (cyc <= 1000) begin
                        check("b2b_gap", gap, RL + 1);
                    end else begin
                        check("b2b_gap_post", 32'(gap == RL + 1 || gap == RL + 1 + RLEN), 1);
                        if (gap == RL + 1 + RLEN) stalls++;
                    end
                end
                last_ack = cyc;
                exp_rdy.push_back(cyc + RL);
                exp_addr.push_back(int'(sdram_addr[AW-1:0]));
                sdram_addr = {14'($urandom), 8'($urandom)};
            end
            exp_now = (exp_rdy.size() > 0) && (exp_rdy[0] == cyc);
            if (data_rdy === 1'b1 || exp_now) begin
                check("b2b_rdy_time", 32'(data_rdy), 32'(exp_now));
                if (exp_now) begin
                    if (data_rdy === 1'b1) check("b2b_data", data_read, exp_word(exp_addr[0]));
                    void'(exp_rdy.pop_front());
                    void'(exp_addr.pop_front());
                end
            end
        end
        check("b2b_drained", exp_rdy.size(), 0);
        check("one_refresh", stalls, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtbubl_sdram_resp.md
JTBUBL_SDRAM_RESP -- requirements
Module: jtbubl_sdram_resp

Interface
REQ-001 Parameter MEM_AW, default 16, SHALL set the log2 depth in 16-bit words of the internal memory.
REQ-002 Parameter READ_LAT, default 4, SHALL set the number of cycles from sdram_ack to data_rdy (range 2..15).
REQ-003 Parameter REF_PERIOD, default 384, SHALL set the number of cycles between refresh requests.
REQ-004 Parameter REF_LEN, default 4, SHALL set the number of busy cycles per refresh.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset: synchronous, active-high.
REQ-007 downloading  in  1  high while ROM load is active.
REQ-008 prog_addr  in  22  write word address.
REQ-009 prog_data  in  8  write byte, replicated on both lanes.
REQ-010 prog_mask  in  2  active-low lane enables: bit0 = low byte, bit1 = high byte.
REQ-011 prog_we  in  1  write request, level-held until sdram_ack.
REQ-012 sdram_req  in  1  read request, level-held until sdram_ack.
REQ-013 sdram_addr  in  22  read word address.
REQ-014 refresh_en  in  1  refresh permitted.
REQ-015 sdram_ack  out  1  one-cycle acceptance pulse for a read or a write.
REQ-016 data_rdy  out  1  one-cycle read-data-valid pulse.
REQ-017 data_read  out  32  {mem[addr+1], mem[addr]}.

Function
REQ-018 The FSM SHALL have four states: IDLE, READ, WRITE and REFRESH.
REQ-019 From IDLE, priority SHALL be: refresh pending with refresh_en high > prog_we while downloading > sdram_req while not downloading.
REQ-020 A read accept SHALL assert sdram_ack for one cycle, latch sdram_addr and enter READ.
REQ-021 data_rdy SHALL pulse exactly READ_LAT cycles after the sdram_ack cycle, with data_read valid in the same cycle; the FSM then returns to IDLE.
REQ-022 data_read SHALL hold its value until the next data_rdy.
REQ-023 The second word of a read SHALL come from (addr+1) mod 2^MEM_AW; only the low MEM_AW address bits are used.
REQ-024 A write accept SHALL assert sdram_ack for one cycle and write prog_data to each lane whose prog_mask bit is 0.
REQ-025 After a write, WRITE SHALL last 2 cycles before returning to IDLE.
REQ-026 A write with prog_mask = 2'b11 SHALL ack and leave memory unchanged.
REQ-027 sdram_req and prog_we SHALL be ignored outside IDLE.
REQ-028 A request still high in the first IDLE cycle after completion SHALL be treated as a new request.
REQ-029 sdram_req while downloading SHALL never be acked.
REQ-030 The refresh counter SHALL count every cycle; reaching REF_PERIOD-1 SHALL set a pending flag and wrap the counter to 0.
REQ-031 Pending refresh SHALL be taken in the next IDLE cycle with refresh_en high; REFRESH SHALL last REF_LEN cycles and clear the pending flag.
REQ-032 With refresh_en low, pending refresh SHALL stay set and SHALL NOT block requests.
REQ-033 A second refresh period expiring while refresh is pending SHALL NOT queue a second refresh.
REQ-034 A deassertion of downloading during READ or WRITE SHALL NOT abort the operation.

Reset
REQ-035 On reset the FSM SHALL go to IDLE, with sdram_ack=0, data_rdy=0, data_read=0, the refresh counter at 0 and the pending flag at 0.
REQ-036 Memory contents SHALL be unaffected by reset.
REQ-037 Reset during READ SHALL suppress the outstanding data_rdy.

Structure
REQ-038 State encodings and default parameter values SHALL live in a shared package, jtbubl_sdram_pkg.
REQ-039 Storage SHALL be one sub-module, jtbubl_sdram_mem: a 16-bit memory with byte-lane write enables and two read ports (addr, addr+1), 1-cycle read latency.

Verification
REQ-040 Download write of 8'hA5 at addr 0x10 with mask 2'b10, then write 8'h3C at addr 0x10 with mask 2'b01; a read of 0x10 SHALL return data_read[15:0]=16'h3CA5 with data_rdy 4 cycles after ack.
REQ-041 Read at addr 2^MEM_AW-1 SHALL return data_read[31:16] = mem[0].
REQ-042 Hold sdram_req high with downloading=1 for 50 cycles: sdram_ack SHALL stay 0; drop downloading and the ack SHALL follow within 1+REF_LEN cycles.
REQ-043 Raise sdram_req in the same cycle a refresh becomes pending, with refresh_en=1: the ack SHALL come exactly REF_LEN cycles later than it would without the refresh.
REQ-044 Assert rst 2 cycles after a read ack: no data_rdy pulse, and all outputs 0 the cycle after reset.
REQ-045 Hold refresh_en=0 for 1000 cycles, then raise it: exactly one REFRESH of REF_LEN cycles, with back-to-back reads unstalled before the raise.
